// File: rtl/sdr_pkg.sv
// Shared helpers for the SDR receive chain: width math and the CIC comb FSM state type.
package sdr_pkg;

  // Ceiling log2 for positive values; used for counter and accumulator sizing.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // CIC register width: input width plus the bit growth of R^N.
  function automatic int cic_acc_w(input int width_in, input int stages, input int decim);
    return width_in + stages * clog2(decim);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COMB = 2'd1,
    ST_OUT  = 2'd2
  } comb_state_e;

endpackage

// File: rtl/cic_integrator_chain.sv
// Cascade of ce-gated modular accumulators forming the CIC integrator section.
module cic_integrator_chain
  import sdr_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int ACC_W    = 41,
  parameter int WIDTH_IN = 8
) (
  input  logic                       osc_clk,
  input  logic                       reset,
  input  logic                       ce,
  input  logic signed [WIDTH_IN-1:0] d_in,
  output logic [ACC_W-1:0]           acc_out
);

  logic [ACC_W-1:0] acc [STAGES];
  logic [ACC_W-1:0] d_in_ext;

  // Overflow is expected here; the comb section cancels the wrap as long as ACC_W covers R^N.
  assign d_in_ext = {{(ACC_W - WIDTH_IN){d_in[WIDTH_IN-1]}}, d_in};
  assign acc_out  = acc[STAGES-1];

  // Each stage adds the previous stage's registered value, giving one cycle of latency per stage.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) acc[k] <= '0;
    end else if (ce) begin
      acc[0] <= acc[0] + d_in_ext;
      for (int k = 1; k < STAGES; k++) acc[k] <= acc[k] + acc[k-1];
    end
  end

endmodule

// File: rtl/cic_decimator.sv
// CIC decimator: integrators at the input rate, a time-multiplexed comb section at the
// output rate, and a square sample clock for the downstream demodulator.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for dec_strobe; latches the integrator output
// ST_COMB | one comb stage per cycle, N cycles
// ST_OUT  | truncates the comb result onto d_out, pulses d_out_valid
module cic_decimator
  import sdr_pkg::*;
#(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 8,
  parameter int STAGES    = 3,
  parameter int DECIM     = 2048
) (
  input  logic                        osc_clk,
  input  logic                        reset,
  input  logic                        ce,
  input  logic signed [WIDTH_IN-1:0]  d_in,
  output logic signed [WIDTH_OUT-1:0] d_out,
  output logic                        d_out_valid,
  output logic                        d_out_clk
);

  localparam int ACC_W  = cic_acc_w(WIDTH_IN, STAGES, DECIM);
  localparam int CNT_W  = clog2(DECIM);
  localparam int STG_W  = clog2(STAGES + 1);
  localparam int HALF_W = clog2(DECIM / 2);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DECIM - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGES - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(DECIM / 2 - 1);

  // The comb pass must finish before the next strobe, and truncation needs WIDTH_OUT <= ACC_W.
  if (STAGES < 1 || STAGES > 6) begin : g_bad_stages
    $error("cic_decimator: STAGES must be in 1..6");
  end
  if (DECIM < 4 || (DECIM & (DECIM - 1)) != 0) begin : g_bad_decim
    $error("cic_decimator: DECIM must be a power of two >= 4");
  end
  if (DECIM < STAGES + 2) begin : g_bad_ratio
    $error("cic_decimator: DECIM must be >= STAGES + 2");
  end
  if (WIDTH_OUT > ACC_W) begin : g_bad_width
    $error("cic_decimator: WIDTH_OUT must not exceed ACC_W");
  end

  logic [ACC_W-1:0]  integ_out;
  logic [CNT_W-1:0]  dec_cnt;
  logic              dec_strobe;
  comb_state_e       state;
  comb_state_e       state_nxt;
  logic [STG_W-1:0]  stage_left;
  logic [ACC_W-1:0]  comb_x;
  logic [ACC_W-1:0]  comb_d [STAGES];
  logic [HALF_W-1:0] clk_left;

  cic_integrator_chain #(
    .STAGES   (STAGES),
    .ACC_W    (ACC_W),
    .WIDTH_IN (WIDTH_IN)
  ) u_integ (
    .osc_clk (osc_clk),
    .reset   (reset),
    .ce      (ce),
    .d_in    (d_in),
    .acc_out (integ_out)
  );

  assign dec_strobe = ce && (dec_cnt == CNT_LAST);

  // Decimation phase counter; DECIM is a power of two so it wraps naturally.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      dec_cnt <= '0;
    end else if (ce) begin
      dec_cnt <= dec_cnt + 1'b1;
    end
  end

  // Comb FSM state register.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Comb FSM next-state: one cycle per comb stage, then a single output cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (dec_strobe) state_nxt = ST_COMB;
      ST_COMB: if (stage_left == '0) state_nxt = ST_OUT;
      ST_OUT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Comb datapath. The delay registers rotate one slot per stage so the head is always the
  // current stage's delay; after N rotations they are back in stage order.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      comb_x      <= '0;
      stage_left  <= '0;
      d_out       <= '0;
      d_out_valid <= 1'b0;
      for (int s = 0; s < STAGES; s++) comb_d[s] <= '0;
    end else begin
      d_out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dec_strobe) begin
            comb_x     <= integ_out;
            stage_left <= STG_LAST;
          end
        end
        ST_COMB: begin
          comb_x <= comb_x - comb_d[0];
          for (int s = 0; s < STAGES - 1; s++) comb_d[s] <= comb_d[s+1];
          comb_d[STAGES-1] <= comb_x;
          if (stage_left != '0) stage_left <= stage_left - 1'b1;
        end
        ST_OUT: begin
          d_out       <= comb_x[ACC_W-1 -: WIDTH_OUT];
          d_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sample clock: rises the cycle after valid, high for DECIM/2 cycles via a down-counter.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      d_out_clk <= 1'b0;
      clk_left  <= '0;
    end else if (d_out_valid) begin
      d_out_clk <= 1'b1;
      clk_left  <= HALF_LAST;
    end else if (d_out_clk) begin
      if (clk_left == '0) begin
        d_out_clk <= 1'b0;
      end else begin
        clk_left <= clk_left - 1'b1;
      end
    end
  end

endmodule
